// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter_if
//  Description : Bundle of the IF, LSU and memory-side signals of the
//                riscv_mem_arbiter. The arbiter connects through the slave
//                modport. The core/memory side (or a bench) connects through
//                the master modport.
//  Signals     : if_*   instruction-fetch request, grant and read response
//                lsu_*  load/store request, grant and response
//                mem_*  single-ported memory request and read data
//                busy_o a transaction is outstanding
//  Revision    : 1.0  initial release
// ============================================================================
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;

  logic                  lsu_req_i;
  logic                  lsu_we_i;
  logic [DATA_W/8-1:0]   lsu_wstrb_i;
  logic [ADDR_W-1:0]     lsu_addr_i;
  logic [DATA_W-1:0]     lsu_wdata_i;
  logic                  lsu_gnt_o;
  logic                  lsu_rvalid_o;
  logic [DATA_W-1:0]     lsu_rdata_o;

  logic                  mem_ce_o;
  logic                  mem_we_o;
  logic [DATA_W/8-1:0]   mem_wstrb_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W-1:0]     mem_rdata_i;

  logic                  busy_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_wstrb_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_ce_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  // Core / memory side
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_wstrb_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_ce_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter
//  Description : Shares one single-ported, fixed-latency memory between the
//                instruction-fetch port (read-only) and the load/store port.
//                At most one transaction is outstanding. Grants are
//                combinational in IDLE, and the response is a one-cycle
//                rvalid pulse MEM_LAT cycles after the grant.
//  Ports       : clk   clock, rising edge
//                rst   synchronous reset, active-low
//                bus   riscv_mem_arbiter_if.slave (IF, LSU, memory, busy)
//  Options     : MEM_ARB_RR_EN  defined   -> round-robin on ties
//                               undefined -> fixed LSU priority
//  Constraints : DATA_W multiple of 8, 1 <= MEM_LAT <= 15, 2**CNT_W > MEM_LAT.
//                The interface instance must use the same ADDR_W/DATA_W.
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_arbiter_if.slave    bus
);

  localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(MEM_LAT);
  localparam logic             OWNER_IF  = 1'b0;
  localparam logic             OWNER_LSU = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             owner_q, owner_d;
  // Remembers whether the in-flight LSU access is a store, so its
  // acknowledge carries zero data instead of whatever the memory returns.
  logic             we_q,    we_d;

  logic any_req;
  logic pick_lsu;
  logic grant;
  logic done;

  assign any_req = bus.if_req_i | bus.lsu_req_i;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;
  // On a tie, grant the requester that did not win last time.
  assign pick_lsu = bus.lsu_req_i & (~bus.if_req_i | (last_owner_q == OWNER_IF));
`else
  assign pick_lsu = bus.lsu_req_i;
`endif

  // Both are qualified by rst so nothing handshakes while reset is held.
  assign grant = rst & (state_q == S_IDLE) & any_req;
  assign done  = rst & (state_q == S_WAIT) & (cnt_q == LAT_CNT);

  assign bus.busy_o = (state_q == S_WAIT);

  always_comb begin
    bus.if_gnt_o     = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = '0;
    bus.lsu_gnt_o    = 1'b0;
    bus.lsu_rvalid_o = 1'b0;
    bus.lsu_rdata_o  = '0;
    bus.mem_ce_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_wstrb_o  = '0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;

    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    if (grant) begin
      bus.mem_ce_o = 1'b1;
      if (pick_lsu) begin
        bus.lsu_gnt_o   = 1'b1;
        bus.mem_we_o    = bus.lsu_we_i;
        bus.mem_wstrb_o = bus.lsu_wstrb_i;
        bus.mem_addr_o  = bus.lsu_addr_i;
        bus.mem_wdata_o = bus.lsu_wdata_i;
      end else begin
        bus.if_gnt_o    = 1'b1;
        bus.mem_addr_o  = bus.if_addr_i;
      end
      state_d = S_WAIT;
      cnt_d   = CNT_W'(1);
      owner_d = pick_lsu ? OWNER_LSU : OWNER_IF;
      we_d    = pick_lsu & bus.lsu_we_i;
`ifdef MEM_ARB_RR_EN
      last_owner_d = pick_lsu ? OWNER_LSU : OWNER_IF;
`endif
    end else if (state_q == S_WAIT) begin
      if (cnt_q != LAT_CNT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    if (done) begin
      if (owner_q == OWNER_LSU) begin
        bus.lsu_rvalid_o = 1'b1;
        bus.lsu_rdata_o  = we_q ? '0 : bus.mem_rdata_i;
      end else begin
        bus.if_rvalid_o  = 1'b1;
        bus.if_rdata_o   = bus.mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= OWNER_IF;
      we_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWNER_IF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_mem_arbiter
//  Description : Directed bench for riscv_mem_arbiter with MEM_LAT = 3.
//                The stimulus queues expected responses (requester, data,
//                cycle) on each grant. A monitor pops and compares them on
//                every rvalid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_mem_arbiter;

  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    bit          lsu;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t sb[$];

  riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 128 words at addr[8:2], read data L edges after sampling.
  logic [31:0] mem  [0:127];
  logic [31:0] pipe [0:L-1];
  assign bus.mem_rdata_i = pipe[L-1];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h0000_0413;
      mem[1]  <= 32'h0000_0513;
      mem[2]  <= 32'h0000_0613;
      mem[3]  <= 32'h0000_0713;
      mem[64] <= 32'h1122_3344;
    end else if (bus.mem_ce_o && bus.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb_o[b]) mem[bus.mem_addr_o[8:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
    if (bus.mem_ce_o) pipe[0] <= bus.mem_we_o ? 32'hBAD0_BAD0 : mem[bus.mem_addr_o[8:2]];
    else              pipe[0] <= 32'hA5A5_5A5A;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Checks one cycle's grant/memory outputs at the negedge, then returns
  // at posedge+1 ready for the next input change.
  task automatic look(input string tag, input bit e_ifg, input bit e_lsug, input bit e_busy,
                      input bit e_we, input logic [3:0] e_strb, input logic [31:0] e_addr,
                      input logic [31:0] e_wdata);
    @(negedge clk);
    chk({tag, ".if_gnt"},  {31'b0, bus.if_gnt_o},  {31'b0, e_ifg});
    chk({tag, ".lsu_gnt"}, {31'b0, bus.lsu_gnt_o}, {31'b0, e_lsug});
    chk({tag, ".busy"},    {31'b0, bus.busy_o},    {31'b0, e_busy});
    chk({tag, ".mem_ce"},  {31'b0, bus.mem_ce_o},  {31'b0, e_ifg | e_lsug});
    chk({tag, ".mem_we"},  {31'b0, bus.mem_we_o},  {31'b0, e_we});
    chk({tag, ".mem_wstrb"}, {28'b0, bus.mem_wstrb_o}, {28'b0, e_strb});
    chk({tag, ".mem_addr"},  bus.mem_addr_o,  e_addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata_o, e_wdata);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < L; i++) look(tag, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic push(input bit lsu, input logic [31:0] data);
    rsp_t e;
    e.lsu  = lsu;
    e.data = data;
    e.due  = cyc + L;
    sb.push_back(e);
  endtask

  // Monitor: every rvalid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.if_rvalid_o || bus.lsu_rvalid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp.unexpected: got if_rvalid=%0b lsu_rvalid=%0b expected none (cycle %0d)",
                 bus.if_rvalid_o, bus.lsu_rvalid_o, cyc);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp.lsu_rvalid", {31'b0, bus.lsu_rvalid_o}, {31'b0, e.lsu});
        chk("rsp.if_rvalid",  {31'b0, bus.if_rvalid_o},  {31'b0, !e.lsu});
        chk("rsp.rdata", e.lsu ? bus.lsu_rdata_o : bus.if_rdata_o, e.data);
        chk("rsp.cycle", cyc, e.due);
      end
    end
    if (!bus.if_rvalid_o)  chk("if_rdata_idle",  bus.if_rdata_o,  32'h0);
    if (!bus.lsu_rvalid_o) chk("lsu_rdata_idle", bus.lsu_rdata_o, 32'h0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_lsu;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.lsu_req_i   = 1'b0;
    bus.lsu_we_i    = 1'b0;
    bus.lsu_wstrb_i = 4'h0;
    bus.lsu_addr_i  = 32'h0;
    bus.lsu_wdata_i = 32'h0;

    // Reset held with both requests asserted: nothing may be granted.
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.if_req_i  = 1'b1;
    bus.lsu_req_i = 1'b1;
    look("reset", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.if_req_i  = 1'b0;
    bus.lsu_req_i = 1'b0;
    rst = 1'b1;
    look("idle", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

    // IF fetch, request held so the next grant lands at T+L+1.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h8000_0000;
    push(0, 32'h0000_0413);
    look("if0", 1, 0, 0, 0, 4'h0, 32'h8000_0000, 32'h0);
    bus.if_addr_i = 32'h8000_0004;
    wait_busy("if0_wait");
    push(0, 32'h0000_0513);
    look("if1", 1, 0, 0, 0, 4'h0, 32'h8000_0004, 32'h0);
    bus.if_req_i = 1'b0;
    wait_busy("if1_wait");

    // Full store, partial store, then load back the merged word.
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b1;
    bus.lsu_wstrb_i = 4'hF;
    bus.lsu_addr_i  = 32'h8000_0100;
    bus.lsu_wdata_i = 32'hDEAD_BEEF;
    push(1, 32'h0);
    look("st0", 0, 1, 0, 1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF);
    bus.lsu_req_i = 1'b0;
    wait_busy("st0_wait");
    bus.lsu_req_i   = 1'b1;
    bus.lsu_wstrb_i = 4'b0101;
    bus.lsu_wdata_i = 32'hCAFE_F00D;
    push(1, 32'h0);
    look("st1", 0, 1, 0, 1, 4'b0101, 32'h8000_0100, 32'hCAFE_F00D);
    bus.lsu_req_i = 1'b0;
    wait_busy("st1_wait");
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b0;
    bus.lsu_wstrb_i = 4'h0;
    bus.lsu_wdata_i = 32'h0;
    push(1, 32'hDEFE_BE0D);
    look("ld0", 0, 1, 0, 0, 4'h0, 32'h8000_0100, 32'h0);
    bus.lsu_req_i = 1'b0;
    wait_busy("ld0_wait");

    // Contention with both requesting continuously (last winner was LSU).
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h8000_0008;
    bus.lsu_req_i  = 1'b1;
    bus.lsu_addr_i = 32'h8000_000C;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (k % 2 == 1);
`else
      exp_lsu = 1'b1;
`endif
      push(exp_lsu, exp_lsu ? 32'h0000_0713 : 32'h0000_0613);
      look("arb", !exp_lsu, exp_lsu, 0, 0, 4'h0,
           exp_lsu ? 32'h8000_000C : 32'h8000_0008, 32'h0);
      wait_busy("arb_wait");
    end
    bus.lsu_req_i = 1'b0;
    push(0, 32'h0000_0613);
    look("arb_if", 1, 0, 0, 0, 4'h0, 32'h8000_0008, 32'h0);
    bus.if_req_i = 1'b0;
    wait_busy("arb_if_wait");

    // LSU request that appears and vanishes entirely inside WAIT.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h8000_0000;
    push(0, 32'h0000_0413);
    look("wd_if", 1, 0, 0, 0, 4'h0, 32'h8000_0000, 32'h0);
    bus.if_req_i   = 1'b0;
    bus.lsu_req_i  = 1'b1;
    bus.lsu_addr_i = 32'h8000_0100;
    look("wd_w1", 0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    bus.lsu_req_i = 1'b0;
    look("wd_w2", 0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    look("wd_w3", 0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h8000_0004;
    push(0, 32'h0000_0513);
    look("wd_if2", 1, 0, 0, 0, 4'h0, 32'h8000_0004, 32'h0);
    bus.if_req_i = 1'b0;
    wait_busy("wd_if2_wait");

    // Reset two cycles into an IF load: its response must never appear.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h8000_0000;
    look("rs_g", 1, 0, 0, 0, 4'h0, 32'h8000_0000, 32'h0);
    bus.if_req_i = 1'b0;
    look("rs_w1", 0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    look("rs_a", 0, 0, 1, 0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    look("rs_p1", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    look("rs_p2", 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h8000_0004;
    push(0, 32'h0000_0513);
    look("rs_new", 1, 0, 0, 0, 4'h0, 32'h8000_0004, 32'h0);
    bus.if_req_i = 1'b0;
    wait_busy("rs_new_wait");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain.pending", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
